uart_rx_framer: RTL

UART_RX_FRAMER -- requirements
Module: uart_rx_framer

---
 rtl/uart_rx_framer_if.sv | 40 ++++
 rtl/uart_rx_framer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: serial-line and received-byte signals of the UART receive framer.
//   rx         serial line into the framer (idle high)
//   bps_clk    bit-sample tick from the baud generator
//   bps_en     baud generator enable, high while a frame is in progress
//   rx_data    last correctly framed byte
//   rx_valid   one-cycle pulse, rx_data updated
//   frame_err  one-cycle pulse, stop bit sampled low
//   parity_err one-cycle pulse, parity mismatch
// master: the framer. slave: the line/baud side and byte consumer.
interface uart_rx_framer_if;
  localparam int unsigned DATA_W = 8;

  logic              rx;
  logic              bps_clk;
  logic              bps_en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_err;
  logic              parity_err;

  modport master (
    input  rx,
    input  bps_clk,
    output bps_en,
    output rx_data,
    output rx_valid,
    output frame_err,
    output parity_err
  );

  modport slave (
    output rx,
    output bps_clk,
    input  bps_en,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  parity_err
  );
endinterface

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: UART receive framer. Synchronizes rx, detects the start edge,
// enables the external baud generator for one frame and samples start, 8 data
// bits (LSB first), optional parity and stop bit on each bps_clk tick.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  uart_rx_framer_if.master (rx, bps_clk in; bps_en, rx_data, rx_valid,
//        frame_err, parity_err out, all registered)
module uart_rx_framer #(
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  uart_rx_framer_if.master   bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rx_meta, rx_s, rx_s_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               par_err_q, par_err_d;
  logic               en_q, en_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               perr_q, perr_d;
  logic               fall_c;

  // rx_s_d tracks rx_s in every state so a start edge landing on the first
  // IDLE cycle (back-to-back frames) is still seen; a held-low line never
  // produces an edge.
  assign fall_c = rx_s_d & ~rx_s;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      en_q      <= en_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  // Next-state and next-output logic; bps_clk only matters outside IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d   = START;
          par_err_d = 1'b0;
        end
      end
      START: begin
        if (bus.bps_clk) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bus.bps_clk) begin
          shift_d = {rx_s, shift_q[DATA_W-1:1]};
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d = PARITY_EN ? PARITY : STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bus.bps_clk) begin
          par_err_d = (^shift_q) ^ rx_s ^ PARITY_ODD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bus.bps_clk) begin
          state_d = IDLE;
          // A low stop bit outranks a parity mismatch.
          if (!rx_s) begin
            ferr_d = 1'b1;
          end else if (par_err_q) begin
            perr_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d = (state_d != IDLE);
  end

  assign bus.bps_en     = en_q;
  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_q;

endmodule
